// File: rtl/stack_engine_pkg.sv
// stack_engine_pkg: shared types for the stack engine.
// Provides the op and state enums and a popcount helper.
package stack_engine_pkg;

   typedef enum logic [1:0] {
      OP_PUSH   = 2'd0,
      OP_POP    = 2'd1,
      OP_ADD_SP = 2'd2,
      OP_SUB_SP = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 64; i++)
         c += 32'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/stack_engine_if.sv
// stack_engine_if: request and memory/register-file bus of the stack engine.
// master = decoder/core side, slave = stack_engine.
interface stack_engine_if #(
   parameter int ADDR_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int IMM_W    = 8
);
   localparam int RW = $clog2(NUM_REGS);

   logic                start;
   logic [1:0]          op;
   logic [NUM_REGS:0]   reg_mask;
   logic [IMM_W-1:0]    imm;
   logic                busy;
   logic                done;
   logic                fault;
   logic [ADDR_W-1:0]   sp_out;
   logic [ADDR_W-1:0]   dmem_addr;
   logic                dmem_wr;
   logic                dmem_rd;
   logic [RW-1:0]       rf_raddr;
   logic                lr_sel;
   logic [RW-1:0]       rf_waddr;
   logic                rf_wr;
   logic                pc_wr;

   modport master (
      output start, op, reg_mask, imm,
      input  busy, done, fault, sp_out,
      input  dmem_addr, dmem_wr, dmem_rd,
      input  rf_raddr, lr_sel, rf_waddr, rf_wr, pc_wr
   );

   modport slave (
      input  start, op, reg_mask, imm,
      output busy, done, fault, sp_out,
      output dmem_addr, dmem_wr, dmem_rd,
      output rf_raddr, lr_sel, rf_waddr, rf_wr, pc_wr
   );

endinterface

// File: rtl/stack_mask_scan.sv
// stack_mask_scan: lowest-set-bit priority encoder.
// In: mask. Out: found, idx (lowest set bit), rest (mask minus that bit).
module stack_mask_scan #(
   parameter int W  = 9,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  mask,
   output logic          found,
   output logic [IW-1:0] idx,
   output logic [W-1:0]  rest
);

   // Descending scan so the lowest set bit is the last to win.
   always_comb begin
      idx = '0;
      for (int i = W - 1; i >= 0; i--)
         if (mask[i])
            idx = IW'(i);
   end

   assign found = |mask;
   assign rest  = mask & (mask - W'(1));

endmodule

// File: rtl/stack_engine.sv
// stack_engine: sequenced PUSH/POP of a register list plus SP adjust.
// Ports: clk, reset (sync, active high), bus (stack_engine_if.slave).
// Optional SP range guard enabled by macro STACK_GUARD_EN.
module stack_engine
   import stack_engine_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 16,
   parameter int                NUM_REGS    = 8,
   parameter int                IMM_W       = 8,
   parameter logic [ADDR_W-1:0] SP_RESET    = 16'hFFFC,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h8000
) (
   input logic           clk,
   input logic           reset,
   stack_engine_if.slave bus
);

   localparam int WB = DATA_W / 8;
   localparam int MW = NUM_REGS + 1;
   localparam int RW = $clog2(NUM_REGS);
   localparam int IW = $clog2(MW);
   localparam int XW = ADDR_W + 1;

   state_e            state;
   op_e               op_q;
   op_e               op_in;
   logic [MW-1:0]     rem_q;
   logic [MW-1:0]     scan_in;
   logic [MW-1:0]     scan_rest;
   logic [IW-1:0]     scan_idx;
   logic [IW-1:0]     idx_q;
   logic              scan_found;
   logic              scan_top;
   logic              top_q;
   logic              cur_push;
   logic              imm_op;
   logic              up;
   logic              viol;
   logic              issue;
   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] sp_fin_q;
   logic [ADDR_W-1:0] sp_calc;
   logic [ADDR_W-1:0] addr_q;
   logic [XW-1:0]     cnt_ext;
   logic [XW-1:0]     delta;
   logic [XW-1:0]     sp_ext;
   logic              busy_q;
   logic              done_q;
   logic              fault_q;
   logic              wr_q;
   logic              rd_q;
   logic              lr_q;
   logic              rf_wr_q;
   logic              pc_wr_q;
   logic [RW-1:0]     raddr_q;
   logic [RW-1:0]     waddr_q;

   assign op_in    = op_e'(bus.op);
   assign imm_op   = (op_in == OP_ADD_SP) || (op_in == OP_SUB_SP);
   // In IDLE scan the incoming list; afterwards the remaining bits.
   assign scan_in  = (state == ST_IDLE) ? bus.reg_mask : rem_q;
   assign scan_top = (scan_idx == IW'(NUM_REGS));
   assign cur_push = (state == ST_IDLE) ? (op_in == OP_PUSH)
                                        : (op_q == OP_PUSH);

   stack_mask_scan #(
      .W  (MW),
      .IW (IW)
   ) u_scan (
      .mask  (scan_in),
      .found (scan_found),
      .idx   (scan_idx),
      .rest  (scan_rest)
   );

   // Final SP of the requested op, one extra bit for carry/borrow.
   always_comb begin
      up      = (op_in == OP_POP) || (op_in == OP_ADD_SP);
      cnt_ext = imm_op ? XW'(bus.imm)
                       : XW'(popcount(64'(bus.reg_mask)));
      delta   = cnt_ext * XW'(WB);
      sp_ext  = up ? ({1'b0, sp_q} + delta)
                   : ({1'b0, sp_q} - delta);
      sp_calc = sp_ext[ADDR_W-1:0];
   end

`ifdef STACK_GUARD_EN
   assign viol = up ? (sp_ext[ADDR_W] || (sp_calc > SP_RESET))
                    : (sp_ext[ADDR_W] || (sp_calc < STACK_LIMIT));
`else
   logic unused_guard;
   assign unused_guard = ^{STACK_LIMIT, sp_ext[ADDR_W]};
   assign viol = 1'b0;
`endif

   // A memory access is presented in the cycle after this is true.
   assign issue = scan_found &&
                  ((state == ST_XFER) ||
                   ((state == ST_IDLE) && bus.start &&
                    !viol && !imm_op));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         op_q     <= OP_PUSH;
         rem_q    <= '0;
         idx_q    <= '0;
         top_q    <= 1'b0;
         sp_q     <= SP_RESET;
         sp_fin_q <= SP_RESET;
         addr_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         lr_q     <= 1'b0;
         rf_wr_q  <= 1'b0;
         pc_wr_q  <= 1'b0;
         raddr_q  <= '0;
         waddr_q  <= '0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         lr_q    <= 1'b0;
         rf_wr_q <= 1'b0;
         pc_wr_q <= 1'b0;
         raddr_q <= '0;
         waddr_q <= '0;
         addr_q  <= '0;

         // Read data returns one cycle after the read strobe.
         if (rd_q) begin
            rf_wr_q <= !top_q;
            pc_wr_q <= top_q;
            waddr_q <= top_q ? '0 : RW'(idx_q);
         end

         if (issue) begin
            wr_q    <= cur_push;
            rd_q    <= !cur_push;
            lr_q    <= cur_push && scan_top;
            raddr_q <= (cur_push && !scan_top) ? RW'(scan_idx) : '0;
            idx_q   <= scan_idx;
            top_q   <= scan_top;
            rem_q   <= scan_rest;
         end

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  op_q     <= op_in;
                  sp_fin_q <= sp_calc;
                  if (viol) begin
                     state   <= ST_DONE;
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                  end else if (imm_op || !scan_found) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                     sp_q   <= sp_calc;
                  end else begin
                     state  <= ST_XFER;
                     busy_q <= 1'b1;
                     addr_q <= (op_in == OP_PUSH) ? sp_calc : sp_q;
                  end
               end
            end
            ST_XFER: begin
               if (scan_found) begin
                  addr_q <= addr_q + ADDR_W'(WB);
               end else if (op_q == OP_POP) begin
                  state <= ST_DRAIN;
               end else begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  sp_q   <= sp_fin_q;
               end
            end
            ST_DRAIN: begin
               state  <= ST_DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               sp_q   <= sp_fin_q;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fault     = fault_q;
   assign bus.sp_out    = sp_q;
   assign bus.dmem_addr = addr_q;
   assign bus.dmem_wr   = wr_q;
   assign bus.dmem_rd   = rd_q;
   assign bus.rf_raddr  = raddr_q;
   assign bus.lr_sel    = lr_q;
   assign bus.rf_waddr  = waddr_q;
   assign bus.rf_wr     = rf_wr_q;
   assign bus.pc_wr     = pc_wr_q;

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: randomized and directed bench for stack_engine.
// Expected traffic comes from a list-level model of the stack.
module tb_stack_engine;

   localparam logic [15:0] SP_RST = 16'hFFFC;
   localparam logic [15:0] LIMIT  = 16'hFFF4;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      int cyc;
      int addr;
      int idx;
      int wr;
   } mem_ev_t;

   typedef struct {
      int cyc;
      int idx;
   } rf_ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   stack_engine_if #(
      .ADDR_W   (16),
      .NUM_REGS (8),
      .IMM_W    (8)
   ) bus ();

   stack_engine #(
      .DATA_W      (32),
      .ADDR_W      (16),
      .NUM_REGS    (8),
      .IMM_W       (8),
      .SP_RESET    (SP_RST),
      .STACK_LIMIT (LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int model_sp;
   int exp_done;
   int exp_busy_end;
   bit exp_fault;
   mem_ev_t exp_mem[$];
   mem_ev_t obs_mem[$];
   rf_ev_t  exp_rf[$];
   rf_ev_t  obs_rf[$];

   // Stack semantics: list in ascending order, lowest register at
   // the lowest address, top bit (LR/PC) at the highest address.
   task automatic model(input int o, input logic [8:0] m, input int im);
      int n;
      int cnt;
      int fin;
      int k;
      bit up;
      bit viol;
      n = 0;
      exp_mem.delete();
      exp_rf.delete();
      for (int i = 0; i < 9; i++)
         if (m[i]) n++;
      cnt = (o >= 2) ? im : n;
      up  = (o == 1) || (o == 2);
      fin = up ? model_sp + cnt * 4 : model_sp - cnt * 4;
      viol = GUARD && (up ? (fin > int'(SP_RST)) : (fin < int'(LIMIT)));
      exp_fault    = viol;
      exp_busy_end = 0;
      exp_done     = 1;
      if (!viol) begin
         if (o < 2 && n > 0) begin
            k = 0;
            for (int i = 0; i < 9; i++) begin
               if (m[i]) begin
                  if (o == 0) begin
                     exp_mem.push_back('{k + 1,
                        (model_sp - n * 4 + k * 4) & 32'hFFFF, i, 1});
                  end else begin
                     exp_mem.push_back('{k + 1,
                        (model_sp + k * 4) & 32'hFFFF, 0, 0});
                     exp_rf.push_back('{k + 2, i});
                  end
                  k++;
               end
            end
            exp_done     = (o == 0) ? n + 1 : n + 2;
            exp_busy_end = exp_done - 1;
         end
         model_sp = fin & 32'hFFFF;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_sp = int'(SP_RST);
   endtask

   task automatic run_op(input string name, input int o,
                         input logic [8:0] m, input int im,
                         input bit poke);
      int c;
      bit got;
      model(o, m, im);
      obs_mem.delete();
      obs_rf.delete();
      @(negedge clk);
      bus.start    = 1'b1;
      bus.op       = 2'(o);
      bus.reg_mask = m;
      bus.imm      = 8'(im);
      @(negedge clk);
      bus.start = 1'b0;
      c   = 1;
      got = 1'b0;
      while (!got && c <= 40) begin
         if (bus.dmem_wr || bus.dmem_rd)
            obs_mem.push_back('{c, int'(bus.dmem_addr),
               bus.dmem_wr ? (bus.lr_sel ? 8 : int'(bus.rf_raddr)) : 0,
               int'(bus.dmem_wr)});
         if (bus.rf_wr || bus.pc_wr)
            obs_rf.push_back('{c, (bus.rf_wr && bus.pc_wr) ? 99 :
               (bus.pc_wr ? 8 : int'(bus.rf_waddr))});
         tests++;
         if (bus.busy !== 1'(c <= exp_busy_end)) begin
            fails++;
            $display("FAIL %s busy cyc %0d: got %b want %b",
                     name, c, bus.busy, (c <= exp_busy_end));
         end
         if (bus.done === 1'b1) begin
            got = 1'b1;
            tests++;
            if (c != exp_done) begin
               fails++;
               $display("FAIL %s done_cycle: got %0d want %0d",
                        name, c, exp_done);
            end
            tests++;
            if (bus.fault !== exp_fault) begin
               fails++;
               $display("FAIL %s fault: got %b want %b",
                        name, bus.fault, exp_fault);
            end
            tests++;
            if (int'(bus.sp_out) != model_sp) begin
               fails++;
               $display("FAIL %s sp: got %h want %h",
                        name, bus.sp_out, model_sp[15:0]);
            end
         end else begin
            if (poke && c == 2) begin
               bus.start = 1'b1;
               bus.op    = 2'd2;
               bus.imm   = 8'd5;
            end
            @(negedge clk);
            if (poke && c == 2) bus.start = 1'b0;
            c++;
         end
      end
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL %s timeout: no done within 40 cycles", name);
      end
      tests++;
      if (obs_mem.size() != exp_mem.size()) begin
         fails++;
         $display("FAIL %s mem_count: got %0d want %0d",
                  name, obs_mem.size(), exp_mem.size());
      end
      for (int i = 0; i < obs_mem.size() && i < exp_mem.size(); i++) begin
         tests++;
         if (obs_mem[i].cyc != exp_mem[i].cyc ||
             obs_mem[i].addr != exp_mem[i].addr ||
             obs_mem[i].idx != exp_mem[i].idx ||
             obs_mem[i].wr != exp_mem[i].wr) begin
            fails++;
            $display("FAIL %s mem[%0d]: got c%0d a%h r%0d w%0d want c%0d a%h r%0d w%0d",
                     name, i, obs_mem[i].cyc, obs_mem[i].addr,
                     obs_mem[i].idx, obs_mem[i].wr, exp_mem[i].cyc,
                     exp_mem[i].addr, exp_mem[i].idx, exp_mem[i].wr);
         end
      end
      tests++;
      if (obs_rf.size() != exp_rf.size()) begin
         fails++;
         $display("FAIL %s rf_count: got %0d want %0d",
                  name, obs_rf.size(), exp_rf.size());
      end
      for (int i = 0; i < obs_rf.size() && i < exp_rf.size(); i++) begin
         tests++;
         if (obs_rf[i].cyc != exp_rf[i].cyc ||
             obs_rf[i].idx != exp_rf[i].idx) begin
            fails++;
            $display("FAIL %s rf[%0d]: got c%0d r%0d want c%0d r%0d",
                     name, i, obs_rf[i].cyc, obs_rf[i].idx,
                     exp_rf[i].cyc, exp_rf[i].idx);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({bus.busy, bus.done, bus.fault, bus.dmem_wr, bus.dmem_rd,
           bus.rf_wr, bus.pc_wr, bus.lr_sel} !== 8'h00) begin
         fails++;
         $display("FAIL reset_strobes: got %b%b%b%b%b%b%b%b want 0",
                  bus.busy, bus.done, bus.fault, bus.dmem_wr,
                  bus.dmem_rd, bus.rf_wr, bus.pc_wr, bus.lr_sel);
      end
      tests++;
      if (bus.sp_out !== SP_RST) begin
         fails++;
         $display("FAIL reset_sp: got %h want %h", bus.sp_out, SP_RST);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      run_op("push_plan", 0, 9'b1_0000_0101, 0, 1'b0);
      run_op("pop_plan", 1, 9'b1_0000_0101, 0, 1'b0);
   endtask

   task automatic test_sp_adjust();
      run_op("sub_sp3", 3, 9'h1FF, 3, 1'b0);
      run_op("add_sp3", 2, 9'h1FF, 3, 1'b0);
   endtask

   task automatic test_empty_and_busy();
      run_op("push_empty", 0, 9'h000, 0, 1'b0);
      run_op("pop_empty", 1, 9'h000, 0, 1'b0);
      do_reset();
      run_op("sub_room", 2, 9'h000, 0, 1'b0);
      run_op("push_poke", 0, 9'h00E, 0, 1'b1);
   endtask

   task automatic test_reset_mid();
      bit bad;
      do_reset();
      @(negedge clk);
      bus.start    = 1'b1;
      bus.op       = 2'd0;
      bus.reg_mask = 9'h006;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.dmem_wr !== 1'b1 || bus.dmem_addr !== 16'hFFF8) begin
         fails++;
         $display("FAIL mid_xfer2: got wr %b addr %h want wr 1 addr fff8",
                  bus.dmem_wr, bus.dmem_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.busy, bus.dmem_wr, bus.dmem_rd, bus.done} !== 4'h0 ||
          bus.sp_out !== SP_RST) begin
         fails++;
         $display("FAIL mid_reset: got busy %b wr %b sp %h want 0 0 fffc",
                  bus.busy, bus.dmem_wr, bus.sp_out);
      end
      reset = 1'b0;
      model_sp = int'(SP_RST);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.dmem_wr || bus.dmem_rd || bus.rf_wr || bus.pc_wr ||
             bus.busy || bus.done)
            bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL mid_quiet: got strobes after reset want none");
      end
   endtask

   task automatic test_guard();
      logic [15:0] want_sp;
      bit want_fault;
`ifdef STACK_GUARD_EN
      want_sp    = 16'hFFFC;
      want_fault = 1'b1;
`else
      want_sp    = 16'hFFF0;
      want_fault = 1'b0;
`endif
      do_reset();
      run_op("guard_push3", 0, 9'h007, 0, 1'b0);
      tests++;
      if (bus.sp_out !== want_sp || bus.fault !== want_fault) begin
         fails++;
         $display("FAIL guard_lit: got sp %h fault %b want sp %h fault %b",
                  bus.sp_out, bus.fault, want_sp, want_fault);
      end
   endtask

   task automatic test_random_back_to_back();
      do_reset();
      for (int t = 0; t < 40; t++)
         run_op("rand", int'($urandom_range(0, 3)),
                9'($urandom_range(0, 511)),
                int'($urandom_range(0, 255)), 1'b0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.op       = 2'd0;
      bus.reg_mask = '0;
      bus.imm      = '0;
      model_sp     = int'(SP_RST);
      test_reset();
      test_push_pop();
      test_sp_adjust();
      test_empty_and_busy();
      test_reset_mid();
      test_guard();
      test_random_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised successor to the stack-top unit. Executes PUSH/POP of an arbitrary register list as a sequenced multi-cycle operation, one memory access per cycle, plus single-cycle SP adjust ops.
- Owns the stack pointer and drives the data-memory address, write enable, register-file read/write addresses and PC write.
- Sits beside the decoder in the processor. The core stalls on busy.

Parameters:
- DATA_W, 32, register/memory word width; must be a multiple of 8.
- ADDR_W, 16, data-memory byte-address and SP width.
- NUM_REGS, 8, general registers in list; mask has NUM_REGS+1 bits (top bit = LR on push / PC on pop).
- IMM_W, 8, SP adjust immediate width, in words.
- SP_RESET, 16'hFFFC, SP value after reset; also the empty-stack top.
- STACK_LIMIT, 16'h8000, lowest legal SP; used only with the guard feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  operation request, sampled in IDLE only
- op  in  2  0=PUSH, 1=POP, 2=ADD_SP, 3=SUB_SP
- reg_mask  in  NUM_REGS+1  register list
- imm  in  IMM_W  word count for ADD_SP/SUB_SP
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse with done on guard violation
- sp_out  out  ADDR_W  current SP
- dmem_addr  out  ADDR_W  memory byte address
- dmem_wr  out  1  memory write strobe
- dmem_rd  out  1  memory read strobe
- rf_raddr  out  $clog2(NUM_REGS)  register to store during PUSH
- lr_sel  out  1  store LR instead of rf_raddr
- rf_waddr  out  $clog2(NUM_REGS)  register loaded during POP
- rf_wr  out  1  register-file write
- pc_wr  out  1  PC load from memory data

Behaviour:
- Reset: SP=SP_RESET, state IDLE, all other outputs 0.
  - Reset mid-operation aborts immediately.
  - No further memory or RF strobes after the reset cycle.
- WB = DATA_W/8. n = popcount(reg_mask).
- Stack is full-descending. Lowest-index register sits at the lowest address; the top mask bit is at the highest address.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - start is accepted only here; start while busy is ignored.
  - On accept, latch op, reg_mask and base address. busy rises the next cycle.
  - PUSH base = SP - n*WB. POP base = SP.
- ADD_SP/SUB_SP:
  - IDLE -> DONE. SP += imm*WB or SP -= imm*WB at the DONE edge.
  - No memory access.
- PUSH, XFER state:
  - One set mask bit per cycle, ascending index order.
  - dmem_wr=1, dmem_addr=base+k*WB for the k-th set bit.
  - rf_raddr = that index; lr_sel=1 for the top bit.
  - After the last bit, go to DONE and write SP = base.
- POP, XFER state:
  - Same address sequence, with dmem_rd=1.
  - Synchronous memory, 1-cycle read latency: rf_wr/rf_waddr are asserted one cycle after the matching dmem_rd.
  - The top bit asserts pc_wr instead of rf_wr.
  - After the last read go to DRAIN (one cycle, finishes the final write), then DONE.
  - SP = base + n*WB at the DONE edge.
- DONE: done=1, busy=0 for one cycle, then IDLE. A new start is accepted in the cycle after DONE.
- Empty mask (n=0) PUSH/POP: IDLE -> DONE, SP unchanged, no strobes.
- Latency:
  - PUSH: n+1 cycles from accept to done.
  - POP: n+2 cycles.
  - ADD_SP/SUB_SP: 1 cycle.
- Arithmetic is modulo 2^ADDR_W. dmem_addr is registered.

Optional Feature:
- Macro STACK_GUARD_EN.
- With it defined:
  - At accept, compute the final SP.
  - PUSH/SUB_SP with final SP < STACK_LIMIT, or borrow, is a violation.
  - POP/ADD_SP with final SP > SP_RESET, or carry, is a violation.
  - On violation go IDLE -> DONE with fault=1 and done=1. SP is unchanged; no memory/RF/PC strobes.
- Without it: fault is tied 0 and SP wraps silently.

Decomposition:
- Package stack_engine_pkg: op enum (OP_PUSH, OP_POP, OP_ADD_SP, OP_SUB_SP), state enum, and function popcount.
- Sub-module stack_mask_scan: a combinational priority encoder giving the lowest set bit index and the mask with that bit cleared.
- Sequencing, SP register and guard logic stay in the top.

Test Plan:
- PUSH, mask 9'b1_0000_0101, SP=16'hFFFC:
  - dmem_wr at FFF0(r0), FFF4(r2), FFF8(LR, lr_sel=1).
  - done at cycle 4; sp_out=FFF0.
- POP, same mask, from SP=FFF0:
  - rf_wr r0, then r2 one cycle after each read.
  - pc_wr on the third write; done at cycle 5; SP=FFFC.
- SUB_SP imm=3 from FFFC: sp_out=FFF0 after 1 cycle, no dmem strobes. Then ADD_SP 3 returns SP to FFFC.
- Empty mask: PUSH with reg_mask=0 gives done next cycle, SP unchanged, no strobes. Assert start during busy of a 3-register push: it is ignored.
- Reset mid-operation: assert reset in the 2nd XFER cycle of a push. Strobes stop, sp_out=FFFC, busy=0.
- With STACK_GUARD_EN, STACK_LIMIT=FFF4, SP=FFFC, PUSH of 3 registers: fault=1 and done=1, no dmem_wr, SP=FFFC. Without the macro: the push completes with SP=FFF0.
